// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared geometry, key indexing and column-state encoding for
//               the 4x3 matrix keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // One state per driven column; COL2 wraps back to COL0.
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } col_state_e;

  // Flat key number used for the keystroke/key_press bit positions.
  function automatic int key_index(input int row, input int col);
    return row * NUM_COLS + col;
  endfunction

  // Active-low column drive pattern for a given column state.
  function automatic logic [NUM_COLS-1:0] col_drive(input col_state_e state);
    logic [NUM_COLS-1:0] drive;
    drive = 3'b110;
    case (state)
      COL0:    drive = 3'b110;
      COL1:    drive = 3'b101;
      COL2:    drive = 3'b011;
      default: drive = 3'b110;
    endcase
    return drive;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Debounce for a single key. The debounced level flips only
//               after DEBOUNCE_SCANS consecutive samples disagree with it; a
//               single agreeing sample restarts the count. A 0->1 flip
//               produces a one-cycle press pulse.
// Ports       : clk_raw   - clock
//               rst_n     - asynchronous active-low reset
//               sample_en - one-cycle strobe: raw is valid for this key
//               raw       - sampled key state, 1 = pressed
//               level     - debounced key level, 1 = pressed
//               press     - one-cycle pulse on debounced 0->1
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk_raw,
  input  logic rst_n,
  input  logic sample_en,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_SCANS + 1);
  // Flip happens on the sample that would bring the count to DEBOUNCE_SCANS,
  // so the counter itself never needs to hold that value.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_SCANS - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sample_en) begin
      if (raw == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_cnt_last) begin
        level_d = ~level_q;
        cnt_d   = '0;
        // raw differs from the old level, so raw=1 means a 0->1 flip
        press_d = raw;
      end else begin
        cnt_d = cnt_q + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Scans a 4x3 active-low matrix keypad one column per scan
//               tick, synchronises the rows and debounces each key.
// Ports       : clk_raw   - clock, all state on rising edge
//               rst_n     - asynchronous active-low reset
//               row_n     - keypad rows, active-low, asynchronous
//               col_n     - column drive, active-low, one bit low
//               keystroke - debounced key levels, bit = row*3 + col
//               key_press - one-cycle pulse per key on debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk_raw,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [NUM_KEYS-1:0] keystroke,
  output logic [NUM_KEYS-1:0] key_press
);

  localparam int                 c_div_w   = $clog2(CLK_DIV);
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);

  // --------------------------------------------------------------------------
  // Row synchroniser (resets to idle / no key)
  // --------------------------------------------------------------------------
  logic [NUM_ROWS-1:0] sync1_q, sync1_d;
  logic [NUM_ROWS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = row_n;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Scan-tick divider
  // --------------------------------------------------------------------------
  logic [c_div_w-1:0] div_q, div_d;
  logic               w_tick;

  assign w_tick = (div_q == c_div_max);

  always_comb begin
    div_d = w_tick ? '0 : div_q + c_div_w'(1);
  end

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // --------------------------------------------------------------------------
  // Column FSM. col_n is registered from the next state so the pins change
  // cleanly on the tick edge rather than through decode logic.
  // --------------------------------------------------------------------------
  col_state_e          col_state_q, col_state_d;
  logic [NUM_COLS-1:0] col_n_q, col_n_d;

  always_comb begin
    col_state_d = col_state_q;
    if (w_tick) begin
      case (col_state_q)
        COL0:    col_state_d = COL1;
        COL1:    col_state_d = COL2;
        COL2:    col_state_d = COL0;
        default: col_state_d = COL0;
      endcase
    end
    col_n_d = col_drive(col_state_d);
  end

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      col_state_q <= COL0;
      col_n_q     <= 3'b110;
    end else begin
      col_state_q <= col_state_d;
      col_n_q     <= col_n_d;
    end
  end

  assign col_n = col_n_q;

  // --------------------------------------------------------------------------
  // Sample-enable decode and per-key debounce. The sample taken on a tick
  // belongs to the column driven during the dwell that the tick ends.
  // --------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] w_sample_en;
  logic [NUM_KEYS-1:0] w_raw;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      localparam int         c_k     = key_index(r, c);
      localparam col_state_e c_state = col_state_e'(c);

      assign w_sample_en[c_k] = w_tick && (col_state_q == c_state);
      assign w_raw[c_k]       = ~sync2_q[r];

      key_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
      ) u_key_debounce (
        .clk_raw   (clk_raw),
        .rst_n     (rst_n),
        .sample_en (w_sample_en[c_k]),
        .raw       (w_raw[c_k]),
        .level     (keystroke[c_k]),
        .press     (key_press[c_k])
      );
    end
  end

endmodule
`default_nettype wire
